// File: rtl/lsu_unit.sv
`default_nettype none
// ============================================================================
// Module   : lsu_unit
// Purpose  : Load/store unit. Runs a req/ack transaction on the data bus,
//            places store data on byte lanes and extends load data.
// Config   : MISALIGN_TRAP_EN - abort misaligned H/HU/W accesses with lsu_err
// Revision : 1.0 - initial release
// ============================================================================
module lsu_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic        lsu_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] c_last = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [29:0]   r_addr;
    logic          r_we;
    logic [2:0]    r_funct3;
    logic [1:0]    r_off;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_req;
    logic          r_done;
    logic          r_err;

    logic          w_illegal;
    logic          w_misalign;
    logic          w_fault;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [1:0]    w_off;
    logic [15:0]   w_sh;
    logic [31:0]   w_load;

    // Decode of the incoming request; w_off is the byte offset actually used
    // for load extraction, so halfword/word ignore the low address bits.
    always_comb begin
        w_be      = 4'b0000;
        w_wdata   = wdata;
        w_off     = 2'b00;
        w_illegal = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
                w_off   = addr[1:0];
            end
            2'b01: begin
                w_be    = 4'b0011 << {addr[1], 1'b0};
                w_wdata = {2{wdata[15:0]}};
                w_off   = {addr[1], 1'b0};
            end
            2'b10: begin
                w_be    = 4'b1111;
            end
            default: w_illegal = 1'b1;
        endcase
        if (funct3[2] && (lsu_we || funct3[1]))
            w_illegal = 1'b1;
    end

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault = w_illegal | w_misalign;

    always_comb begin
        w_sh = 16'(bus_rdata >> {r_off, 3'b000});
        case (r_funct3)
            3'b000:  w_load = {{24{w_sh[7]}}, w_sh[7:0]};
            3'b001:  w_load = {{16{w_sh[15]}}, w_sh[15:0]};
            3'b100:  w_load = {24'b0, w_sh[7:0]};
            3'b101:  w_load = {16'b0, w_sh[15:0]};
            default: w_load = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_off    <= 2'b00;
            r_be     <= 4'b0000;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_req    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (lsu_valid) begin
                        r_addr   <= addr[31:2];
                        r_we     <= lsu_we;
                        r_funct3 <= funct3;
                        r_off    <= w_off;
                        r_be     <= w_be;
                        r_wdata  <= w_wdata;
                        r_cnt    <= '0;
                        if (w_fault) begin
                            r_state <= S_ERR;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (bus_ack) begin
                        r_state <= S_DONE;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        if (!r_we)
                            r_rdata <= w_load;
                    end else if (r_cnt == c_last) begin
                        r_state <= S_ERR;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign lsu_stall = lsu_valid & ~r_done;
    assign lsu_done  = r_done;
    assign lsu_err   = r_err;
    assign rdata     = r_rdata;
    assign bus_req   = r_req;
    assign bus_we    = r_we;
    assign bus_addr  = {r_addr, 2'b00};
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_unit
// Purpose  : Self-checking bench for lsu_unit (TIMEOUT=4), vector table plus
//            reset and idle-ack sequences, results checked via a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_unit;

    localparam int c_timeout = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, lsu_we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        lsu_stall, lsu_done, lsu_err;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_rdata = '0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          ack_at;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] load;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          reqs;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];

    lsu_unit #(.TIMEOUT(c_timeout)) dut (
        .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .lsu_we(lsu_we),
        .funct3(funct3), .addr(addr), .wdata(wdata), .lsu_stall(lsu_stall),
        .lsu_done(lsu_done), .lsu_err(lsu_err), .rdata(rdata), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        exp_t e, got;
        int   n = 0;
        int   reqs = 0;
        bit   done_seen = 1'b0;
        e.err   = v.fault || (v.ack_at < 0) || (v.ack_at >= c_timeout);
        e.rdata = e.err ? 32'h0 : (v.we ? model_rdata : v.load);
        e.reqs  = v.fault ? 0 : ((v.ack_at < 0 || v.ack_at >= c_timeout) ? c_timeout : v.ack_at + 1);
        model_rdata = e.rdata;
        sb.push_back(e);
        @(negedge clk);
        lsu_valid = 1'b1; lsu_we = v.we; funct3 = v.f3; addr = v.a; wdata = v.wd;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        while (!done_seen && n < 40) begin
            @(negedge clk);
            n++;
            bus_ack = 1'b0;
            if (lsu_done) begin
                done_seen = 1'b1;
                got = sb.pop_front();
                chk($sformatf("v%0d err", idx), {31'b0, lsu_err}, {31'b0, got.err});
                chk($sformatf("v%0d rdata", idx), rdata, got.rdata);
                chk($sformatf("v%0d req_cycles", idx), reqs, got.reqs);
                chk($sformatf("v%0d latency", idx), n, got.reqs + 1);
                chk($sformatf("v%0d stall_at_done", idx), {31'b0, lsu_stall}, 32'h0);
                chk($sformatf("v%0d req_at_done", idx), {31'b0, bus_req}, 32'h0);
            end else begin
                chk($sformatf("v%0d stall", idx), {31'b0, lsu_stall}, 32'h1);
                if (bus_req) begin
                    if (reqs == 0) begin
                        chk($sformatf("v%0d bus_addr", idx), bus_addr, {v.a[31:2], 2'b00});
                        chk($sformatf("v%0d bus_be", idx), {28'b0, bus_be}, {28'b0, v.be});
                        chk($sformatf("v%0d bus_we", idx), {31'b0, bus_we}, {31'b0, v.we});
                        if (v.we)
                            chk($sformatf("v%0d bus_wdata", idx), bus_wdata, v.bwd);
                    end
                    if (reqs == v.ack_at) begin
                        bus_ack = 1'b1;
                        bus_rdata = v.rd;
                    end
                    reqs++;
                end
            end
        end
        if (!done_seen) begin
            failures++;
            $display("FAIL v%0d done_timeout: got no lsu_done expected lsu_done within 40 cycles", idx);
            void'(sb.pop_front());
        end
        lsu_valid = 1'b0; bus_ack = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d idle_req", idx), {31'b0, bus_req}, 32'h0);
        chk($sformatf("v%0d idle_done", idx), {31'b0, lsu_done}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; lsu_valid = 1'b0; lsu_we = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;

        //        we  f3      addr          wdata         bus_rdata     ack fault be      bus_wdata     load
        vecs[0]  = '{1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0,         1, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h2000_0003, 32'h0,         32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 3'b100, 32'h2000_0003, 32'h0,         32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0,         32'h0000_0080};
        vecs[3]  = '{1'b1, 3'b001, 32'h2000_0002, 32'h0000_ABCD, 32'h0,         0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[4]  = '{1'b0, 3'b001, 32'h2000_0002, 32'h0,         32'h8001_0000, 2, 1'b0, 4'b1100, 32'h0,         32'hFFFF_8001};
        vecs[5]  = '{1'b0, 3'b010, 32'h2000_0000, 32'h0,         32'h1234_5678, -1, 1'b0, 4'b1111, 32'h0,        32'h0};
        vecs[6]  = '{1'b0, 3'b010, 32'h2000_0000, 32'h0,         32'h1234_5678, 3, 1'b0, 4'b1111, 32'h0,         32'h1234_5678};
`ifdef MISALIGN_TRAP_EN
        vecs[7]  = '{1'b0, 3'b010, 32'h3000_0001, 32'h0,         32'hCAFE_F00D, 0, 1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[8]  = '{1'b0, 3'b001, 32'h4000_0003, 32'h0,         32'hBEEF_0000, 0, 1'b1, 4'b0000, 32'h0,         32'h0};
`else
        vecs[7]  = '{1'b0, 3'b010, 32'h3000_0001, 32'h0,         32'hCAFE_F00D, 0, 1'b0, 4'b1111, 32'h0,         32'hCAFE_F00D};
        vecs[8]  = '{1'b0, 3'b001, 32'h4000_0003, 32'h0,         32'hBEEF_0000, 0, 1'b0, 4'b1100, 32'h0,         32'hFFFF_BEEF};
`endif
        vecs[9]  = '{1'b0, 3'b011, 32'h3000_0000, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[10] = '{1'b1, 3'b100, 32'h3000_0000, 32'h1,         32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[11] = '{1'b0, 3'b101, 32'h4000_0000, 32'h0,         32'h1111_F00D, 0, 1'b0, 4'b0011, 32'h0,         32'h0000_F00D};
        vecs[12] = '{1'b1, 3'b000, 32'h5000_0001, 32'h0000_00A5, 32'h0,         1, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[13] = '{1'b0, 3'b000, 32'h5000_0001, 32'h0,         32'h0000_7F00, 0, 1'b0, 4'b0010, 32'h0,         32'h0000_007F};
        vecs[14] = '{1'b1, 3'b010, 32'h6000_0008, 32'h0BAD_CAFE, 32'h0,         0, 1'b0, 4'b1111, 32'h0BAD_CAFE, 32'h0};
        vecs[15] = '{1'b0, 3'b111, 32'h6000_0000, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};

        repeat (2) @(negedge clk);
        chk("rst bus_req", {31'b0, bus_req}, 32'h0);
        chk("rst done", {31'b0, lsu_done}, 32'h0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst bus_be", {28'b0, bus_be}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++)
            run(i, vecs[i]);

        // bus_ack while idle must not start or complete anything
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        chk("idle_ack req", {31'b0, bus_req}, 32'h0);
        chk("idle_ack done", {31'b0, lsu_done}, 32'h0);
        bus_ack = 1'b0;

        // reset while REQ is waiting for ack
        lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'b010; addr = 32'h7000_0000;
        repeat (2) @(negedge clk);
        chk("rst_mid req_before", {31'b0, bus_req}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid req_async", {31'b0, bus_req}, 32'h0);
        lsu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_rdata = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_mid no_done", {31'b0, lsu_done}, 32'h0);
            chk("rst_mid no_req", {31'b0, bus_req}, 32'h0);
        end
        chk("rst_mid rdata", rdata, 32'h0);
        run(16, vecs[6]);
        chk("sb empty", sb.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
